// File: rtl/echo_tone_pkg.sv
// Shared types and widths for the echo_tone audio stage.
// Used by echo_tone, echo_avg4 and echo_tone_if (ECHO_TONE_AVG_EN selects the filter flavour).
package echo_tone_pkg;

  localparam int CNT_W = 16;
  localparam int SUM_W = 18;
  localparam int HP_W  = 24;

  typedef enum logic {
    ST_MUTE = 1'b0,
    ST_RUN  = 1'b1
  } tone_state_t;

  // Zero-extend before shifting so SHIFT up to 8 never loses upper bits.
  function automatic logic [HP_W-1:0] half_period(input logic [CNT_W-1:0] filt,
                                                  input int unsigned      shift);
    logic [HP_W-1:0] wide;
    wide = {{(HP_W-CNT_W){1'b0}}, filt};
    return wide << shift;
  endfunction

endpackage

// File: rtl/echo_tone_if.sv
// Measurement-in / tone-out bundle between the echo engine side and echo_tone.
interface echo_tone_if;
  import echo_tone_pkg::*;

  logic             en;
  logic [CNT_W-1:0] echo_cnt;
  logic             echo_vld;
  logic             audio_o;
  logic             tone_on;
  logic [HP_W-1:0]  half_per_o;
  logic [CNT_W-1:0] filt_o;

  modport master (
    output en, echo_cnt, echo_vld,
    input  audio_o, tone_on, half_per_o, filt_o
  );

  modport slave (
    input  en, echo_cnt, echo_vld,
    output audio_o, tone_on, half_per_o, filt_o
  );

endinterface

// File: rtl/echo_avg4.sv
// Echo-count filter: 4-tap moving average with priming when ECHO_TONE_AVG_EN is
// defined, otherwise a plain sample register. Both give filt one edge after echo_vld.
module echo_avg4
  import echo_tone_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             echo_vld,
  input  logic [CNT_W-1:0] echo_cnt,
  output logic [CNT_W-1:0] filt,
  output logic             upd
);

  logic accept;
  assign accept = en & echo_vld;

`ifdef ECHO_TONE_AVG_EN

  logic [CNT_W-1:0] taps     [4];
  logic [CNT_W-1:0] taps_nxt [4];
  logic [SUM_W-1:0] sum_nxt;
  logic             primed;

  always_comb begin
    for (int i = 0; i < 4; i++) taps_nxt[i] = taps[i];
    if (accept) begin
      if (!primed) begin
        // First sample after reset or enable fills the whole window.
        for (int i = 0; i < 4; i++) taps_nxt[i] = echo_cnt;
      end else begin
        taps_nxt[0] = echo_cnt;
        for (int i = 1; i < 4; i++) taps_nxt[i] = taps[i-1];
      end
    end
    sum_nxt = SUM_W'(taps_nxt[0]) + SUM_W'(taps_nxt[1])
            + SUM_W'(taps_nxt[2]) + SUM_W'(taps_nxt[3]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) taps[i] <= '0;
      primed <= 1'b0;
      filt   <= '0;
      upd    <= 1'b0;
    end else begin
      upd <= accept;
      if (!en) begin
        primed <= 1'b0;
      end else if (accept) begin
        primed <= 1'b1;
      end
      if (accept) begin
        for (int i = 0; i < 4; i++) taps[i] <= taps_nxt[i];
        filt <= sum_nxt[SUM_W-1:2];
      end
    end
  end

`else

  always_ff @(posedge clk) begin
    if (reset) begin
      filt <= '0;
      upd  <= 1'b0;
    end else begin
      upd <= accept;
      if (accept) begin
        filt <= echo_cnt;
      end
    end
  end

`endif

endmodule

// File: rtl/echo_tone.sv
// Echo count to square-wave tone: filter (echo_avg4, ECHO_TONE_AVG_EN selects averaging),
// range check, mute/run FSM and half-period phase counter.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_MUTE | audio held low, phase counter at 0, waiting for in-range update
//   ST_RUN  | audio toggles every half_per_o cycles
module echo_tone
  import echo_tone_pkg::*;
#(
  parameter logic [CNT_W-1:0] MIN_CNT = 16'd100,
  parameter logic [CNT_W-1:0] MAX_CNT = 16'd20000,
  parameter int unsigned      SHIFT   = 2
) (
  input logic        clk,
  input logic        reset,
  echo_tone_if.slave bus
);

  logic [CNT_W-1:0] filt;
  logic             upd1;

  logic [HP_W-1:0]  tgt_q;
  logic             in_rng_q;
  logic             upd2_q;

  tone_state_t      state;
  logic [HP_W-1:0]  phase_cnt;
  logic [HP_W-1:0]  half_per_q;
  logic             audio_q;
  logic             tone_q;

  echo_avg4 u_avg (
    .clk      (clk),
    .reset    (reset),
    .en       (bus.en),
    .echo_vld (bus.echo_vld),
    .echo_cnt (bus.echo_cnt),
    .filt     (filt),
    .upd      (upd1)
  );

  // Target and range are registered every cycle; upd2_q marks a fresh filter result.
  always_ff @(posedge clk) begin
    if (reset) begin
      tgt_q    <= '0;
      in_rng_q <= 1'b0;
      upd2_q   <= 1'b0;
    end else begin
      tgt_q    <= half_period(filt, SHIFT);
      in_rng_q <= (filt >= MIN_CNT) && (filt <= MAX_CNT);
      upd2_q   <= upd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_MUTE;
      phase_cnt  <= '0;
      half_per_q <= '0;
      audio_q    <= 1'b0;
      tone_q     <= 1'b0;
    end else begin
      case (state)
        ST_MUTE: begin
          audio_q   <= 1'b0;
          tone_q    <= 1'b0;
          phase_cnt <= '0;
          if (bus.en && upd2_q && in_rng_q) begin
            state      <= ST_RUN;
            tone_q     <= 1'b1;
            half_per_q <= tgt_q;
          end
        end
        ST_RUN: begin
          if (!bus.en || (upd2_q && !in_rng_q)) begin
            state     <= ST_MUTE;
            audio_q   <= 1'b0;
            tone_q    <= 1'b0;
            phase_cnt <= '0;
          end else if (phase_cnt == half_per_q - 1'b1) begin
            // New period only takes effect at a toggle, so no short half-cycle.
            audio_q    <= ~audio_q;
            phase_cnt  <= '0;
            half_per_q <= tgt_q;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        default: begin
          state     <= ST_MUTE;
          audio_q   <= 1'b0;
          tone_q    <= 1'b0;
          phase_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.audio_o    = audio_q;
  assign bus.tone_on    = tone_q;
  assign bus.half_per_o = half_per_q;
  assign bus.filt_o     = filt;

endmodule

// File: tb/tb_echo_tone.sv
// Self-checking bench for echo_tone: directed sequences, a range-bound table,
// and randomized traffic against an event-time reference model.
module tb_echo_tone;
  import echo_tone_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  echo_tone_if ifa ();
  echo_tone_if ifb ();

  echo_tone #(.SHIFT(2)) dut  (.clk(clk), .reset(reset), .bus(ifa));
  echo_tone #(.SHIFT(8)) dut8 (.clk(clk), .reset(reset), .bus(ifb));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present inputs for one rising edge, return at the following falling edge.
  task automatic drive(input logic e, input logic v, input logic [15:0] c);
    ifa.en       = e;
    ifa.echo_vld = v;
    ifa.echo_cnt = c;
    @(negedge clk);
  endtask

  task automatic wait_level(input logic lvl, input int budget, output int n);
    n = 0;
    while (ifa.audio_o !== lvl && n < budget) begin
      drive(1'b1, 1'b0, 16'd0);
      n++;
    end
  endtask

  // ---------------- reference model (SHIFT=2, bounds 100..20000) ----------------
  int m_cyc, m_hp, m_next, m_filt, m_f1, m_f2;
  int m_taps[4];
  bit m_run, m_audio, m_primed, m_u1, m_u2;

  function automatic bit in_range(input int f);
    return (f >= 100) && (f <= 20000);
  endfunction

  task automatic model_reset();
    m_run = 0; m_audio = 0; m_hp = 0; m_next = 0; m_filt = 0;
    m_primed = 0; m_u1 = 0; m_u2 = 0; m_f1 = 0; m_f2 = 0;
    foreach (m_taps[i]) m_taps[i] = 0;
  endtask

  task automatic model_step(input bit r, input bit e, input bit v, input int c);
    bit upd;
    m_cyc++;
    if (r) begin
      model_reset();
      return;
    end
    // Decisions see the filter value produced two edges earlier.
    if (m_run) begin
      if (!e || (m_u2 && !in_range(m_f2))) begin
        m_run = 0; m_audio = 0;
      end else if (m_cyc == m_next) begin
        m_audio = !m_audio;
        m_hp    = m_f2 * 4;
        m_next  = m_cyc + m_hp;
      end
    end else if (e && m_u2 && in_range(m_f2)) begin
      m_run  = 1;
      m_hp   = m_f2 * 4;
      m_next = m_cyc + m_hp;
    end
    upd = e && v;
    if (upd) begin
`ifdef ECHO_TONE_AVG_EN
      if (!m_primed) begin
        foreach (m_taps[i]) m_taps[i] = c;
      end else begin
        m_taps[3] = m_taps[2]; m_taps[2] = m_taps[1]; m_taps[1] = m_taps[0]; m_taps[0] = c;
      end
      m_primed = 1;
      m_filt = (m_taps[0] + m_taps[1] + m_taps[2] + m_taps[3]) / 4;
`else
      m_filt = c;
`endif
    end
    if (!e) m_primed = 0;
    m_u2 = m_u1; m_f2 = m_f1;
    m_u1 = upd;  m_f1 = m_filt;
  endtask

  typedef struct {
    logic [15:0] cnt;
    logic        tone;
    logic [23:0] hp;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int n, n2;
    tbl[0] = '{cnt: 16'd99,    tone: 1'b0, hp: 24'd0};
    tbl[1] = '{cnt: 16'd100,   tone: 1'b1, hp: 24'd400};
    tbl[2] = '{cnt: 16'd20000, tone: 1'b1, hp: 24'd400};
    tbl[3] = '{cnt: 16'd20001, tone: 1'b0, hp: 24'd400};
    tbl[4] = '{cnt: 16'd20000, tone: 1'b1, hp: 24'd80000};
    tbl[5] = '{cnt: 16'd99,    tone: 1'b0, hp: 24'd80000};

    reset = 1'b1;
    ifa.en = 1'b0; ifa.echo_vld = 1'b0; ifa.echo_cnt = '0;
    ifb.en = 1'b0; ifb.echo_vld = 1'b0; ifb.echo_cnt = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, 16'd0);
    check("rst_audio", ifa.audio_o, 0);
    check("rst_tone",  ifa.tone_on, 0);
    check("rst_hp",    ifa.half_per_o, 0);
    check("rst_filt",  ifa.filt_o, 0);

    // Basic tone at 1000; SHIFT=8 instance gets 20000 in parallel.
    ifb.en = 1'b1; ifb.echo_vld = 1'b1; ifb.echo_cnt = 16'd20000;
    drive(1'b1, 1'b1, 16'd1000);
    ifb.echo_vld = 1'b0;
    check("basic_filt_n1", ifa.filt_o, 1000);
    check("basic_tone_n1", ifa.tone_on, 0);
    drive(1'b1, 1'b0, 16'd0);
    check("basic_tone_n2", ifa.tone_on, 0);
    drive(1'b1, 1'b0, 16'd0);
    check("basic_tone_n3", ifa.tone_on, 1);
    check("basic_hp",      ifa.half_per_o, 4000);
    check("basic_audio0",  ifa.audio_o, 0);
    check("shift8_hp",     ifb.half_per_o, 5120000);
    check("shift8_tone",   ifb.tone_on, 1);
    wait_level(1'b1, 10000, n);
    check("basic_first_toggle", n, 4000);
    wait_level(1'b0, 10000, n);
    check("basic_high_len", n, 4000);

    // Averaging right after a toggle: current low level keeps old period.
    drive(1'b1, 1'b1, 16'd2000);
`ifdef ECHO_TONE_AVG_EN
    check("avg_filt1", ifa.filt_o, 1250);
    drive(1'b1, 1'b1, 16'd2000); check("avg_filt2", ifa.filt_o, 1500);
    drive(1'b1, 1'b1, 16'd2000); check("avg_filt3", ifa.filt_o, 1750);
`else
    check("avg_filt1", ifa.filt_o, 2000);
    drive(1'b1, 1'b1, 16'd2000); check("avg_filt2", ifa.filt_o, 2000);
    drive(1'b1, 1'b1, 16'd2000); check("avg_filt3", ifa.filt_o, 2000);
`endif
    drive(1'b1, 1'b1, 16'd2000); check("avg_filt4", ifa.filt_o, 2000);
    check("avg_hp_held", ifa.half_per_o, 4000);
    wait_level(1'b1, 10000, n);
    check("avg_low_len", n + 4, 4000);
    check("avg_hp_new", ifa.half_per_o, 8000);
    wait_level(1'b0, 10000, n);
    check("avg_high_len", n, 8000);

    // Enable drop while audio is high, ignored sample, re-enable re-primes.
    wait_level(1'b1, 9000, n);
    check("en_wait_high", ifa.audio_o, 1);
    drive(1'b0, 1'b0, 16'd0);
    check("endrop_audio", ifa.audio_o, 0);
    check("endrop_tone",  ifa.tone_on, 0);
    check("endrop_hp",    ifa.half_per_o, 8000);
    drive(1'b0, 1'b1, 16'd777);
    check("dis_vld_filt", ifa.filt_o, 2000);
    drive(1'b1, 1'b1, 16'd500);
    check("reen_filt", ifa.filt_o, 500);
    drive(1'b1, 1'b0, 16'd0);
    drive(1'b1, 1'b0, 16'd0);
    check("reen_tone", ifa.tone_on, 1);
    check("reen_hp",   ifa.half_per_o, 2000);

    // Reset while the tone is high.
    wait_level(1'b1, 3000, n);
    check("rst_wait_high", ifa.audio_o, 1);
    reset = 1'b1;
    drive(1'b1, 1'b0, 16'd0);
    reset = 1'b0;
    check("midrst_audio", ifa.audio_o, 0);
    check("midrst_tone",  ifa.tone_on, 0);
    check("midrst_hp",    ifa.half_per_o, 0);
    check("midrst_filt",  ifa.filt_o, 0);
    drive(1'b1, 1'b1, 16'd3000);
    check("midrst_reprime", ifa.filt_o, 3000);

    // Range bounds from a primed window: four equal samples per entry.
    reset = 1'b1;
    drive(1'b0, 1'b0, 16'd0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      repeat (4) drive(1'b1, 1'b1, tbl[i].cnt);
      repeat (4) drive(1'b1, 1'b0, 16'd0);
      check($sformatf("rng%0d_filt", i), ifa.filt_o, 32'(tbl[i].cnt));
      check($sformatf("rng%0d_tone", i), ifa.tone_on, 32'(tbl[i].tone));
      check($sformatf("rng%0d_hp", i),   ifa.half_per_o, 32'(tbl[i].hp));
    end

    // Randomized traffic against the reference model.
    reset = 1'b1;
    drive(1'b0, 1'b0, 16'd0);
    m_cyc = 0;
    model_reset();
    for (int k = 0; k < 8000; k++) begin
      bit r, e, v;
      int c;
      check("rnd_out", {14'd0, ifa.audio_o, ifa.tone_on, ifa.filt_o},
            {14'd0, m_audio, m_run, 16'(m_filt)});
      check("rnd_hp", ifa.half_per_o, m_hp);
      r = ($urandom_range(0, 1499) == 0);
      e = ($urandom_range(0, 59) != 0);
      v = ($urandom_range(0, 24) == 0);
      n2 = $urandom_range(0, 9);
      c = (n2 == 0) ? $urandom_range(20001, 20100) : $urandom_range(85, 140);
      reset = r;
      model_step(r, e, v, c);
      drive(e, v, 16'(c));
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
